instr_fetch_unit: RTL and testbench

//  Front-end fetch stage of the out-of-order core; sits directly upstream of decode/rename inside cpu_top.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_queue.sv | 46 ++++
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core types: datapath widths, the fetch-queue entry, and the fetch FSM states.
package cpu_pkg;
    localparam int XLEN    = 32;
    localparam int IMEM_AW = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries. Pointers carry an extra wrap bit so that full and empty are distinguishable.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         empty
);
    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         full;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // The upstream credit check must never let a push land on a full queue.
    assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, credit-limited imem requests, response kill on redirect, fetch queue to decode.
// Optional IFETCH_STATS_EN adds saturating stat_fetched / stat_stall counters.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_pc,
    output logic [XLEN-1:0]    if_instr,
    input  logic               id_ready
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_stall
`endif
);
    localparam int QW = $clog2(FQ_DEPTH);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, req_pc;
    logic            inflight, kill;
    logic            push, pop, q_empty, credit_ok;
    logic [QW:0]     q_count, occ;
    fetch_entry_t    head, push_data;

    // Queued entries plus the response still on its way; never exceeds FQ_DEPTH.
    assign occ       = q_count + {{QW{1'b0}}, inflight};
    assign credit_ok = occ < (QW+1)'(FQ_DEPTH);
    assign imem_addr = pc[IMEM_AW+1:2];

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                imem_req = credit_ok && !redirect_valid;
                if (halt) state_nxt = HALT;
            end
            HALT:    if (!halt) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= imem_req;
            kill     <= redirect_valid;
            if (imem_req) req_pc <= pc;
            if (redirect_valid)
                pc <= redirect_pc & ~XLEN'(3);
            else if (imem_req)
                pc <= pc + XLEN'(4);
        end
    end

    // A redirect flushes the queue this edge and drops whatever response is arriving.
    assign push            = inflight && !kill && !redirect_valid;
    assign push_data.pc    = req_pc;
    assign push_data.instr = imem_rdata;
    assign if_valid        = !q_empty && !redirect_valid;
    assign pop             = if_valid && id_ready;
    assign if_pc           = q_empty ? '0 : head.pc;
    assign if_instr        = q_empty ? '0 : head.instr;

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (q_count),
        .empty     (q_empty)
    );

`ifdef IFETCH_STATS_EN
    logic stall;
    assign stall = (state == RUN) && !credit_ok && !redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
        end else begin
            if (push && stat_fetched != 32'hFFFF_FFFF) stat_fetched <= stat_fetched + 1'b1;
            if (stall && stat_stall != 32'hFFFF_FFFF)  stat_stall   <= stat_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector tables plus hand sequences for wrap and mid-run reset.
module tb_instr_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req, halt, redirect_valid, if_valid, id_ready;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata, redirect_pc, if_pc, if_instr;
    logic        w_req, w_vld;
    logic [7:0]  w_addr;
    logic [31:0] w_rdata, w_pc, w_instr;
`ifdef IFETCH_STATS_EN
    logic [31:0] s_f, s_s, ws_f, ws_s;
`endif

    typedef struct {
        logic        rdy, hlt, rv;
        logic [31:0] rpc;
        logic        req;
        logic [7:0]  addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vq[$];
    int   errors = 0, checks = 0;

    always #5 clk = ~clk;

    // imem word i holds A000_0000 + i, one-cycle read latency
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'hA000_0000 | {24'h0, imem_addr};
        if (w_req)    w_rdata    <= 32'hA000_0000 | {24'h0, w_addr};
    end

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .halt(halt), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .id_ready(id_ready)
`ifdef IFETCH_STATS_EN
        , .stat_fetched(s_f), .stat_stall(s_s)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .halt(1'b0), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .if_valid(w_vld), .if_pc(w_pc),
        .if_instr(w_instr), .id_ready(1'b1)
`ifdef IFETCH_STATS_EN
        , .stat_fetched(ws_f), .stat_stall(ws_s)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic rdy, input logic hlt, input logic rv,
                                input logic [31:0] rpc, input logic req, input logic [7:0] addr,
                                input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rdy = rdy; v.hlt = hlt; v.rv = rv; v.rpc = rpc;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        vq.push_back(v);
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, ".req"},   32'(imem_req),  32'h0);
        chk({nm, ".addr"},  32'(imem_addr), 32'h0);
        chk({nm, ".vld"},   32'(if_valid),  32'h0);
        chk({nm, ".pc"},    if_pc,          32'h0);
        chk({nm, ".instr"}, if_instr,       32'h0);
    endtask

    // Leaves time at posedge+1 of cycle 0 after release, inputs idle with id_ready=1.
    task automatic do_reset();
        reset = 1'b1; id_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
    endtask

    task automatic run_vecs(input string tn);
        foreach (vq[i]) begin
            id_ready = vq[i].rdy; halt = vq[i].hlt;
            redirect_valid = vq[i].rv; redirect_pc = vq[i].rpc;
            #1;
            chk($sformatf("%s[%0d].req", tn, i), 32'(imem_req), 32'(vq[i].req));
            if (vq[i].req) chk($sformatf("%s[%0d].addr", tn, i), 32'(imem_addr), 32'(vq[i].addr));
            chk($sformatf("%s[%0d].vld", tn, i), 32'(if_valid), 32'(vq[i].vld));
            if (vq[i].vld) begin
                chk($sformatf("%s[%0d].pc", tn, i), if_pc, vq[i].pc);
                chk($sformatf("%s[%0d].instr", tn, i), if_instr, 32'hA000_0000 | {24'h0, vq[i].pc[9:2]});
            end
            @(posedge clk);
            #1;
        end
        vq.delete();
    endtask

    function automatic void start_vecs(input logic rdy);
        add(rdy, 0, 0, 0, 0, 0, 0, 0);
        add(rdy, 0, 0, 0, 1, 0, 0, 0);
        add(rdy, 0, 0, 0, 1, 1, 0, 0);
        add(rdy, 0, 0, 0, 1, 2, 1, 0);
    endfunction

    initial begin
        // streaming with decode always ready
        do_reset();
        start_vecs(1);
        for (int k = 1; k < 4; k++) add(1, 0, 0, 0, 1, 8'(k + 2), 1, 32'(4 * k));
        run_vecs("stream");

        // backpressure: credit limits to four requests, then drains in order
        do_reset();
        start_vecs(0);
        add(0, 0, 0, 0, 1, 3, 1, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k < 5; k++) add(1, 0, 0, 0, 1, 8'(k + 3), 1, 32'(4 * k));
        run_vecs("bp");

        // redirect with 3 queued + 1 in flight, then back-to-back redirects
        do_reset();
        start_vecs(0);
        add(0, 0, 0, 0, 1, 3, 1, 0);
        add(0, 0, 1, 32'h43, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 8'h10, 0, 0);
        add(1, 0, 0, 0, 1, 8'h11, 0, 0);
        add(1, 0, 0, 0, 1, 8'h12, 1, 32'h40);
        add(1, 0, 0, 0, 1, 8'h13, 1, 32'h44);
        add(1, 0, 1, 32'h100, 0, 0, 0, 0);
        add(1, 0, 1, 32'h202, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 8'h80, 0, 0);
        add(1, 0, 0, 0, 1, 8'h81, 0, 0);
        add(1, 0, 0, 0, 1, 8'h82, 1, 32'h200);
        run_vecs("redir");

        // PC wrap from 0xFFFF_FFFC
        do_reset();
        #1;
        chk("wrap.c0.req", 32'(w_req), 32'h0);
        @(posedge clk); #2;
        chk("wrap.c1.req", 32'(w_req), 32'h1);
        chk("wrap.c1.addr", 32'(w_addr), 32'hFF);
        @(posedge clk); #2;
        chk("wrap.c2.req", 32'(w_req), 32'h1);
        chk("wrap.c2.addr", 32'(w_addr), 32'h0);
        @(posedge clk); #2;
        chk("wrap.c3.vld", 32'(w_vld), 32'h1);
        chk("wrap.c3.pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap.c3.instr", w_instr, 32'hA000_00FF);
        @(posedge clk); #2;
        chk("wrap.c4.pc", w_pc, 32'h0);
        chk("wrap.c4.instr", w_instr, 32'hA000_0000);

        // halt while a response is in flight: it is still delivered, no new requests
        do_reset();
        start_vecs(0);
        add(0, 0, 0, 0, 1, 3, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k < 4; k++) add(1, 1, 0, 0, 0, 0, 1, 32'(4 * k));
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 4, 0, 0);
        add(1, 0, 0, 0, 1, 5, 0, 0);
        add(1, 0, 0, 0, 1, 6, 1, 32'h10);
        run_vecs("halt");

        // asynchronous reset with a nearly full queue and a response in flight
        do_reset();
        start_vecs(0);
        add(0, 0, 0, 0, 1, 3, 1, 0);
        run_vecs("prefill");
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        do_reset();
        start_vecs(1);
        add(1, 0, 0, 0, 1, 3, 1, 4);
        run_vecs("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
